io1out_pad: RTL and testbench

- Output-direction counterpart of the 1-bit input pad tile.
- Selects one of four routing-track signals (pin_0..pin_3), optionally inverts and registers it, and drives it with an output enable to the top-level pad.
- Configured through a small addressed config bus with write and read-back.
- One instance per output IO tile in the fabric.

---
 rtl/io1out_pad.sv | 92 +++++++++
 tb/tb_io1out_pad.sv | 139 +++++++++++++
 2 files changed

// File: rtl/io1out_pad.sv
// Output IO tile: picks one of four routing tracks, optionally inverts and
// registers it, and drives the pad with a registered output enable.
module io1out_pad #(
  parameter logic [7:0] TILE_ID   = 8'h00,
  parameter logic       INIT      = 1'b0,
  parameter logic [7:0] CFG_RESET = 8'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_0,
  input  logic       pin_1,
  input  logic       pin_2,
  input  logic       pin_3,
  input  logic [7:0] config_addr,
  input  logic [7:0] config_data,
  input  logic       config_we,
  input  logic       config_re,
  output logic [7:0] config_rdata,
  output logic       config_rvalid,
  output logic       top_pin,
  output logic       top_oe
);

  localparam logic [7:0] CFG_MASK = 8'h1F;

  logic [7:0] cfg_q, cfg_d;
  logic       q_q, q_d;
  logic       oe_q, oe_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;

  logic       addr_hit;
  logic [1:0] sel;
  logic       reg_mode;
  logic       invert;
  logic       pin_sel;
  logic       d;

  assign addr_hit = (config_addr == TILE_ID);
  assign sel      = cfg_q[1:0];
  assign reg_mode = cfg_q[2];
  assign invert   = cfg_q[3];

  always_comb begin
    pin_sel = pin_0;
    unique case (sel)
      2'd0: pin_sel = pin_0;
      2'd1: pin_sel = pin_1;
      2'd2: pin_sel = pin_2;
      2'd3: pin_sel = pin_3;
      default: pin_sel = pin_0;
    endcase
    d = pin_sel ^ invert;
  end

  always_comb begin
    cfg_d    = cfg_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    // Read samples cfg_q, so a same-cycle write is not visible to the read.
    if (config_we && addr_hit) cfg_d = {3'b000, config_data[4:0]};
    if (config_re && addr_hit) begin
      rdata_d  = cfg_q;
      rvalid_d = 1'b1;
    end
    // q tracks d in bypass mode too, so entering registered mode is never stale.
    q_d  = d;
    oe_d = cfg_q[4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= CFG_RESET & CFG_MASK;
      q_q      <= INIT;
      oe_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      q_q      <= q_d;
      oe_q     <= oe_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign top_pin       = reg_mode ? q_q : d;
  assign top_oe        = oe_q;
  assign config_rdata  = rdata_q;
  assign config_rvalid = rvalid_q;

endmodule

// File: tb/tb_io1out_pad.sv
// Directed bench for io1out_pad: reset, mux/invert/register paths, config bus.
module tb_io1out_pad;

  localparam logic [7:0] TID = 8'h3A;

  logic       clk, rst;
  logic       pin_0, pin_1, pin_2, pin_3;
  logic [7:0] config_addr, config_data;
  logic       config_we, config_re;
  logic [7:0] config_rdata;
  logic       config_rvalid, top_pin, top_oe;

  int unsigned tests = 0;
  int unsigned fails = 0;

  io1out_pad #(.TILE_ID(TID), .INIT(1'b1), .CFG_RESET(8'h04)) dut (
    .clk(clk), .rst(rst),
    .pin_0(pin_0), .pin_1(pin_1), .pin_2(pin_2), .pin_3(pin_3),
    .config_addr(config_addr), .config_data(config_data),
    .config_we(config_we), .config_re(config_re),
    .config_rdata(config_rdata), .config_rvalid(config_rvalid),
    .top_pin(top_pin), .top_oe(top_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    {pin_0, pin_1, pin_2, pin_3} = 4'b0000;
    config_addr = TID; config_data = '0; config_we = 1'b0; config_re = 1'b0;
    #1;
    // Reset held with pins toggling.
    for (int i = 0; i < 3; i++) begin
      {pin_0, pin_1, pin_2, pin_3} = (i % 2 == 0) ? 4'b0000 : 4'b1111;
      tick();
      check("rst_pin", {7'd0, top_pin}, 8'd1);
      check("rst_oe", {7'd0, top_oe}, 8'd0);
      check("rst_rvalid", {7'd0, config_rvalid}, 8'd0);
    end
    rst = 1'b0;
    pin_0 = 1'b0;
    #1 check("post_rst_pin", {7'd0, top_pin}, 8'd1);
    tick(); check("reg_pin0_lo", {7'd0, top_pin}, 8'd0);
    pin_0 = 1'b1;
    #1 check("reg_latency", {7'd0, top_pin}, 8'd0);
    tick(); check("reg_pin0_hi", {7'd0, top_pin}, 8'd1);

    // Write 0x12: sel 2, bypass, oe on.
    config_data = 8'h12; config_we = 1'b1;
    tick(); config_we = 1'b0;
    check("oe_1cyc", {7'd0, top_oe}, 8'd0);
    pin_2 = 1'b1; #1 check("byp_hi", {7'd0, top_pin}, 8'd1);
    pin_2 = 1'b0; #1 check("byp_lo", {7'd0, top_pin}, 8'd0);
    tick(); check("oe_2cyc", {7'd0, top_oe}, 8'd1);
    config_re = 1'b1;
    tick(); config_re = 1'b0;
    check("rd12_valid", {7'd0, config_rvalid}, 8'd1);
    check("rd12_data", config_rdata, 8'h12);
    tick();
    check("rd12_drop", {7'd0, config_rvalid}, 8'd0);
    check("rd12_hold", config_rdata, 8'h12);

    // Write 0xFF: reserved bits dropped; sel 3, registered, inverted.
    config_data = 8'hFF; config_we = 1'b1;
    tick(); config_we = 1'b0; config_re = 1'b1;
    pin_3 = 1'b0;
    tick(); config_re = 1'b0;
    check("rdFF_data", config_rdata, 8'h1F);
    check("inv_p3_0", {7'd0, top_pin}, 8'd1);
    pin_3 = 1'b1;
    #1 check("inv_latency", {7'd0, top_pin}, 8'd1);
    tick(); check("inv_p3_1", {7'd0, top_pin}, 8'd0);

    // Address mismatch: no write, no read response.
    config_addr = TID + 8'd1; config_data = 8'h00; config_we = 1'b1;
    tick(); config_we = 1'b0; config_re = 1'b1;
    tick();
    check("miss_rvalid", {7'd0, config_rvalid}, 8'd0);
    tick(); config_re = 1'b0;
    check("miss_rvalid2", {7'd0, config_rvalid}, 8'd0);
    config_addr = TID; config_re = 1'b1;
    tick(); config_re = 1'b0;
    check("miss_cfg", config_rdata, 8'h1F);

    // Same-cycle write and read.
    config_data = 8'h04; config_we = 1'b1;
    tick();
    config_data = 8'h01; config_re = 1'b1;
    tick(); config_we = 1'b0;
    check("rw_old", config_rdata, 8'h04);
    check("rw_valid", {7'd0, config_rvalid}, 8'd1);
    tick(); config_re = 1'b0;
    check("rw_new", config_rdata, 8'h01);
    check("b2b_valid", {7'd0, config_rvalid}, 8'd1);
    tick(); check("b2b_drop", {7'd0, config_rvalid}, 8'd0);

    // Asynchronous reset mid-cycle with oe on and rvalid high.
    config_data = 8'h1B; config_we = 1'b1;
    tick(); config_we = 1'b0;
    pin_3 = 1'b1;
    tick(); check("pre_oe", {7'd0, top_oe}, 8'd1);
    config_re = 1'b1;
    tick(); config_re = 1'b0;
    check("pre_rvalid", {7'd0, config_rvalid}, 8'd1);
    check("pre_rdata", config_rdata, 8'h1B);
    check("pre_pin", {7'd0, top_pin}, 8'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_oe", {7'd0, top_oe}, 8'd0);
    check("arst_rvalid", {7'd0, config_rvalid}, 8'd0);
    check("arst_pin", {7'd0, top_pin}, 8'd1);
    check("arst_rdata", config_rdata, 8'h00);
    config_data = 8'h1F; config_we = 1'b1;
    tick(); config_we = 1'b0;
    rst = 1'b0;
    config_re = 1'b1;
    tick(); config_re = 1'b0;
    check("arst_cfg", config_rdata, 8'h04);
    check("arst_rv2", {7'd0, config_rvalid}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
